// File: rtl/conv_layer_sched_pkg.sv
// Shared accelerator definitions: scheduler FSM encoding, default pipeline timing
// and the layout of the control word carried alongside conv results.
package conv_layer_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_STREAM,
        ST_DRAIN,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam int CONV_LAT_DEFAULT = 4;
    localparam int CLR_CYC_DEFAULT  = 2;

    // Control word bit positions: valid, first input channel, last input channel.
    localparam int CTRL_W     = 3;
    localparam int CTRL_VALID = 2;
    localparam int CTRL_FIRST = 1;
    localparam int CTRL_LAST  = 0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// Fixed-depth shift register that keeps control flags aligned with the conv
// pipeline latency; cleared by the layer reset.
module ctrl_delay_line #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_reg [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (!rst_n) stage_reg[gi] <= '0;
                    else        stage_reg[gi] <= din;
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (!rst_n) stage_reg[gi] <= '0;
                    else        stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/conv_layer_sched.sv
// Convolution layer scheduler: walks every (in_ch, out_ch) pass, clearing the
// line buffers, streaming pixels and draining the conv pipeline before moving on.
module conv_layer_sched
    import conv_layer_sched_pkg::*;
#(
    parameter int PIX_W    = 16,
    parameter int CH_W     = 8,
    parameter int CONV_LAT = CONV_LAT_DEFAULT,
    parameter int CLR_CYC  = CLR_CYC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [PIX_W-1:0] cfg_pixels,
    input  logic [CH_W-1:0] cfg_in_ch,
    input  logic [CH_W-1:0] cfg_out_ch,
    input  logic            pix_valid,
    output logic            busy,
    output logic            rst_n_conv,
    output logic            valid_in_conv,
    output logic            valid_in_accu,
    output logic            accu_first,
    output logic            valid_in_maxpool,
    output logic [CH_W-1:0] in_ch_idx,
    output logic [CH_W-1:0] out_ch_idx,
    output logic            task_over
);

    localparam int PH_W = $clog2(max_int(CONV_LAT, CLR_CYC) + 1);

    state_t           state_reg, state_next;
    logic [PIX_W-1:0] pix_cnt_reg, pix_cnt_next;
    logic [PH_W-1:0]  ph_cnt_reg, ph_cnt_next;
    logic [CH_W-1:0]  in_ch_reg, in_ch_next;
    logic [CH_W-1:0]  out_ch_reg, out_ch_next;
    logic [PIX_W-1:0] cfg_pixels_reg;
    logic [CH_W-1:0]  cfg_in_ch_reg, cfg_out_ch_reg;
    logic             cfg_load;
    logic             rst_n_conv_reg;
    logic             in_last, out_last;
    logic [CTRL_W-1:0] ctrl_in, ctrl_out;

    assign in_last  = (in_ch_reg  == cfg_in_ch_reg  - CH_W'(1));
    assign out_last = (out_ch_reg == cfg_out_ch_reg - CH_W'(1));

    always_comb begin
        state_next   = state_reg;
        pix_cnt_next = pix_cnt_reg;
        ph_cnt_next  = ph_cnt_reg;
        in_ch_next   = in_ch_reg;
        out_ch_next  = out_ch_reg;
        cfg_load     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    cfg_load     = 1'b1;
                    pix_cnt_next = '0;
                    ph_cnt_next  = '0;
                    in_ch_next   = '0;
                    out_ch_next  = '0;
                    // A degenerate layer completes without touching the datapath.
                    if (cfg_pixels == '0 || cfg_in_ch == '0 || cfg_out_ch == '0)
                        state_next = ST_DONE;
                    else
                        state_next = ST_CLR;
                end
            end
            ST_CLR: begin
                if (ph_cnt_reg == PH_W'(CLR_CYC - 1)) begin
                    ph_cnt_next = '0;
                    state_next  = ST_STREAM;
                end else begin
                    ph_cnt_next = ph_cnt_reg + PH_W'(1);
                end
            end
            ST_STREAM: begin
                if (pix_valid) begin
                    if (pix_cnt_reg == cfg_pixels_reg - PIX_W'(1)) begin
                        pix_cnt_next = '0;
                        state_next   = ST_DRAIN;
                    end else begin
                        pix_cnt_next = pix_cnt_reg + PIX_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (ph_cnt_reg == PH_W'(CONV_LAT - 1)) begin
                    ph_cnt_next = '0;
                    state_next  = ST_NEXT;
                end else begin
                    ph_cnt_next = ph_cnt_reg + PH_W'(1);
                end
            end
            ST_NEXT: begin
                if (in_last) begin
                    in_ch_next = '0;
                    if (out_last) begin
                        state_next = ST_DONE;
                    end else begin
                        out_ch_next = out_ch_reg + CH_W'(1);
                        state_next  = ST_CLR;
                    end
                end else begin
                    in_ch_next = in_ch_reg + CH_W'(1);
                    state_next = ST_CLR;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            pix_cnt_reg    <= '0;
            ph_cnt_reg     <= '0;
            in_ch_reg      <= '0;
            out_ch_reg     <= '0;
            cfg_pixels_reg <= '0;
            cfg_in_ch_reg  <= '0;
            cfg_out_ch_reg <= '0;
            rst_n_conv_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pix_cnt_reg    <= pix_cnt_next;
            ph_cnt_reg     <= ph_cnt_next;
            in_ch_reg      <= in_ch_next;
            out_ch_reg     <= out_ch_next;
            // Registered from the next state so the clear is glitch-free and low exactly while in CLR.
            rst_n_conv_reg <= (state_next != ST_CLR);
            if (cfg_load) begin
                cfg_pixels_reg <= cfg_pixels;
                cfg_in_ch_reg  <= cfg_in_ch;
                cfg_out_ch_reg <= cfg_out_ch;
            end
        end
    end

    assign valid_in_conv = (state_reg == ST_STREAM) && pix_valid;

    assign ctrl_in[CTRL_VALID] = valid_in_conv;
    assign ctrl_in[CTRL_FIRST] = valid_in_conv && (in_ch_reg == '0);
    assign ctrl_in[CTRL_LAST]  = valid_in_conv && in_last;

    ctrl_delay_line #(
        .DEPTH (CONV_LAT),
        .WIDTH (CTRL_W)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ctrl_in),
        .dout  (ctrl_out)
    );

    assign valid_in_accu    = ctrl_out[CTRL_VALID];
    assign accu_first       = ctrl_out[CTRL_FIRST];
    assign valid_in_maxpool = ctrl_out[CTRL_LAST];

    assign busy       = (state_reg != ST_IDLE);
    assign task_over  = (state_reg == ST_DONE);
    assign rst_n_conv = rst_n_conv_reg;
    assign in_ch_idx  = in_ch_reg;
    assign out_ch_idx = out_ch_reg;

endmodule
